// File: rtl/cdc_bus_arbiter_pkg.sv
// cdc_bus_arbiter_pkg: shared FSM state type and id-width helper for the cdc_bus arbiter.
package cdc_bus_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cdc_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after i_ptr, wrapping.
module rr_arbiter
   import cdc_bus_arbiter_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = id_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt_onehot,
   output logic [IW-1:0] o_gnt_id,
   output logic          o_any
);
   always_comb begin
      int idx;
      o_any = |i_req;
      o_gnt_id = '0;
      o_gnt_onehot = '0;
      // scan from the far end so the nearest request to i_ptr wins
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(i_ptr) + k) % N;
         if (i_req[idx]) o_gnt_id = idx[IW-1:0];
      end
      if (o_any) o_gnt_onehot[o_gnt_id] = 1'b1;
   end
endmodule

// File: rtl/cdc_bus_arbiter.sv
// cdc_bus_arbiter: per-port holding slots serialised round-robin onto one cdc_bus crossing,
// with done pulses, drop detection and a crossing-time watchdog.
module cdc_bus_arbiter
   import cdc_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_WIDTH = id_w(NUM_REQ)
) (
   input  logic                           i_aclk,
   input  logic                           i_areset,
   input  logic                           i_enable,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]             o_req_ready,
   output logic [NUM_REQ-1:0]             o_req_done,
   output logic [NUM_REQ-1:0]             o_drop_err,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] o_cdc_bus,
   output logic                           o_cdc_valid,
   input  logic                           i_cdc_ready,
   output logic                           o_busy,
   output logic [ID_WIDTH-1:0]            o_grant_id,
   output logic                           o_timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

   state_t r_state, w_next;
   logic [NUM_REQ-1:0] r_pending, r_done, r_drop_err, r_grant_oh;
   logic [DATA_WIDTH-1:0] r_slot [NUM_REQ];
   logic [ID_WIDTH+DATA_WIDTH-1:0] r_cdc_bus;
   logic r_cdc_valid, r_timeout;
   logic [ID_WIDTH-1:0] r_grant_id, r_ptr;
   logic [WD_W-1:0] r_wdog;
   logic [NUM_REQ-1:0] w_gnt_onehot, w_cap, w_drop;
   logic [ID_WIDTH-1:0] w_gnt_id;
   logic w_any, w_issue, w_ack;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req(r_pending),
      .i_ptr(r_ptr),
      .o_gnt_onehot(w_gnt_onehot),
      .o_gnt_id(w_gnt_id),
      .o_any(w_any)
   );

   always_comb begin
      w_issue = (r_state == IDLE) && i_enable && w_any && i_cdc_ready;
      w_ack = (r_state == WAIT) && i_cdc_ready;
      w_next = w_issue ? ISSUE : (r_state == ISSUE) ? WAIT : w_ack ? IDLE : r_state;
      w_cap = i_req_valid & ~r_pending;
      w_drop = i_req_valid & r_pending;
   end

   always_ff @(posedge i_aclk) begin
      if (i_areset) r_state <= IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         r_pending <= '0;
         r_done <= '0;
         r_drop_err <= '0;
         r_grant_oh <= '0;
         r_cdc_bus <= '0;
         r_cdc_valid <= 1'b0;
         r_timeout <= 1'b0;
         r_grant_id <= '0;
         r_ptr <= '0;
         r_wdog <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_slot[i] <= '0;
      end else begin
         // a port's own request in its done cycle still sees pending and is dropped
         r_pending <= (r_pending & ~(w_ack ? r_grant_oh : '0)) | w_cap;
         r_done <= w_ack ? r_grant_oh : '0;
         r_drop_err <= r_drop_err | w_drop;
         r_cdc_valid <= w_issue;
         if (w_issue) begin
            r_grant_id <= w_gnt_id;
            r_grant_oh <= w_gnt_onehot;
            r_cdc_bus <= {w_gnt_id, r_slot[w_gnt_id]};
         end
         if (w_ack) r_ptr <= (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
         if (r_state == ISSUE) r_wdog <= '0;
         else if (r_state == WAIT && r_wdog != WD_MAX) r_wdog <= r_wdog + 1'b1;
         if (r_state == WAIT && r_wdog == WD_MAX - 1'b1) r_timeout <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++)
            if (w_cap[i]) r_slot[i] <= i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign o_req_ready = ~r_pending;
   assign o_req_done = r_done;
   assign o_drop_err = r_drop_err;
   assign o_cdc_bus = r_cdc_bus;
   assign o_cdc_valid = r_cdc_valid;
   assign o_busy = r_state != IDLE;
   assign o_grant_id = r_grant_id;
   assign o_timeout_err = r_timeout;
endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// tb_cdc_bus_arbiter: directed and random stimulus checked every cycle against a
// transaction-level model of the arbiter (pending slots, rr pointer, crossing age).
module tb_cdc_bus_arbiter;
   localparam int N = 4, DW = 32, TO = 8, IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, rdy;
   logic [N-1:0] rv;
   logic [N*DW-1:0] rd;
   logic [N-1:0] o_req_ready, o_req_done, o_drop_err;
   logic [IW+DW-1:0] o_cdc_bus;
   logic o_cdc_valid, o_busy, o_timeout_err;
   logic [IW-1:0] o_grant_id;

   cdc_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_aclk(clk), .i_areset(rst), .i_enable(en), .i_req_valid(rv), .i_req_data(rd),
      .o_req_ready(o_req_ready), .o_req_done(o_req_done), .o_drop_err(o_drop_err),
      .o_cdc_bus(o_cdc_bus), .o_cdc_valid(o_cdc_valid), .i_cdc_ready(rdy), .o_busy(o_busy),
      .o_grant_id(o_grant_id), .o_timeout_err(o_timeout_err)
   );

   bit m_pend [N];
   logic [DW-1:0] m_slot [N];
   int m_ptr, m_cur, m_age, m_gid;
   logic [IW+DW-1:0] m_bus;
   logic m_valid, m_to;
   logic [N-1:0] m_done, m_drop;

   int n_chk = 0, n_pass = 0;
   int ack_delay = 3;
   bit idle_rdy = 1;
   int xq[$];
   logic [DW-1:0] xd[$];
   int done_cnt [N];
   int exp_order [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_slot[i] = '0;
      end
      m_ptr = 0; m_cur = -1; m_age = 0; m_gid = 0;
      m_bus = '0; m_valid = 0; m_to = 0; m_done = '0; m_drop = '0;
   endfunction

   function automatic bit any_pend();
      bit a = 0;
      for (int i = 0; i < N; i++) a |= m_pend[i];
      return a;
   endfunction

   function automatic void model_step();
      bit old [N];
      int g = -1;
      int p;
      m_valid = 0;
      m_done = '0;
      if (rst) begin
         model_reset();
         return;
      end
      old = m_pend;
      if (m_cur >= 0) begin
         // age 1 is the issue cycle; age k>=2 is the (k-1)th wait cycle
         if (m_age >= 2 && m_age - 1 >= TO) m_to = 1;
         if (m_age >= 2 && rdy) begin
            m_done[m_cur] = 1;
            m_pend[m_cur] = 0;
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
         end else m_age++;
      end else if (en && rdy) begin
         for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (g < 0 && old[p]) g = p;
         end
         if (g >= 0) begin
            m_cur = g; m_age = 1; m_gid = g; m_valid = 1;
            m_bus = {IW'(g), m_slot[g]};
         end
      end
      for (int i = 0; i < N; i++)
         if (rv[i]) begin
            if (old[i]) m_drop[i] = 1;
            else begin
               m_pend[i] = 1;
               m_slot[i] = rd[i*DW +: DW];
            end
         end
   endfunction

   task automatic compare_all();
      logic [N-1:0] e;
      for (int i = 0; i < N; i++) e[i] = !m_pend[i];
      chk("req_ready", o_req_ready, e);
      chk("req_done", o_req_done, m_done);
      chk("drop_err", o_drop_err, m_drop);
      chk("cdc_valid", o_cdc_valid, m_valid);
      chk("cdc_bus", o_cdc_bus, m_bus);
      chk("busy", o_busy, m_cur >= 0);
      chk("timeout_err", o_timeout_err, m_to);
      if (m_cur >= 0) chk("grant_id", o_grant_id, m_gid);
      for (int i = 0; i < N; i++) done_cnt[i] += int'(o_req_done[i]);
      if (o_cdc_valid) begin
         xq.push_back(int'(o_cdc_bus[IW+DW-1:DW]));
         xd.push_back(o_cdc_bus[DW-1:0]);
      end
   endtask

   task automatic tick();
      rdy = (m_cur < 0) ? idle_rdy : (m_age - 1 >= ack_delay);
      @(posedge clk);
      model_step();
      #1 compare_all();
      rv = '0;
   endtask

   task automatic pulse(input int port, input logic [DW-1:0] d);
      rv[port] = 1'b1;
      rd[port*DW +: DW] = d;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 400 && (m_cur >= 0 || any_pend()); i++) tick();
      if (m_cur >= 0 || any_pend()) chk("drain_bound", 1, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; rv = '0; rd = '0; rdy = 1'b1;
      for (int i = 0; i < N; i++) done_cnt[i] = 0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", o_req_ready, 4'hF);
      chk("rst_busy", o_busy, 0);
      chk("rst_bus", o_cdc_bus, 0);

      ack_delay = 10;
      pulse(2, 32'hDEADBEEF);
      tick();
      chk("t1_valid", o_cdc_valid, 1);
      chk("t1_bus", o_cdc_bus, {2'd2, 32'hDEADBEEF});
      drain();
      chk("t1_done", done_cnt[2], 1);
      chk("t1_ready", o_req_ready[2], 1);

      do_reset();
      ack_delay = 3;
      xq.delete();
      rv = 4'hF;
      rd = {$urandom, $urandom, $urandom, $urandom};
      tick();
      for (int i = 0; i < 100 && m_cur != 1; i++) tick();
      pulse(0, $urandom);
      drain();
      chk("t2_count", xq.size(), 5);
      for (int i = 0; i < 5 && i < xq.size(); i++) chk("t2_order", xq[i], exp_order[i]);

      xq.delete(); xd.delete();
      pulse(1, 32'hA);
      pulse(1, 32'hB);
      drain();
      chk("t3_drop", o_drop_err[1], 1);
      chk("t3_count", xq.size(), 1);
      if (xd.size() > 0) chk("t3_data", xd[0], 32'hA);

      xq.delete();
      pulse(0, $urandom);
      for (int i = 0; i < 50 && !(m_cur == 0 && m_age >= 2); i++) tick();
      en = 1'b0;
      pulse(3, $urandom);
      for (int i = 0; i < 50 && m_cur >= 0; i++) tick();
      idle(6);
      chk("t4_idle", o_busy, 0);
      chk("t4_held", o_req_ready[3], 0);
      chk("t4_one", xq.size(), 1);
      en = 1'b1;
      drain();
      if (xq.size() > 0) chk("t4_last", xq[$], 3);

      do_reset();
      ack_delay = 20;
      pulse(0, $urandom);
      idle(9);
      chk("t5_pre", o_timeout_err, 0);
      tick();
      chk("t5_to", o_timeout_err, 1);
      chk("t5_busy", o_busy, 1);
      done_cnt[0] = 0;
      drain();
      chk("t5_done", done_cnt[0], 1);
      chk("t5_sticky", o_timeout_err, 1);

      ack_delay = 30;
      pulse(1, $urandom);
      idle(4);
      done_cnt[1] = 0;
      do_reset();
      chk("t6_busy", o_busy, 0);
      chk("t6_ready", o_req_ready, 4'hF);
      idle(3);
      chk("t6_nodone", done_cnt[1], 0);
      ack_delay = 3;
      xq.delete();
      pulse(2, $urandom);
      drain();
      chk("t6_cross", xq.size(), 1);
      if (xq.size() > 0) chk("t6_id", xq[0], 2);

      do_reset();
      for (int c = 0; c < 600; c++) begin
         en = $urandom_range(0, 9) != 0;
         idle_rdy = $urandom_range(0, 5) != 0;
         if (m_cur < 0) ack_delay = $urandom_range(0, 12);
         for (int i = 0; i < N; i++) begin
            rv[i] = $urandom_range(0, 3) == 0;
            rd[i*DW +: DW] = $urandom;
         end
         tick();
      end
      en = 1'b1; idle_rdy = 1; ack_delay = 2;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
